// File: rtl/vp_validate_if.sv
// vp_validate_if: bundles the E1 prediction, writeback and feedback signals
// of vp_validate. Optional statistics outputs exist only when
// VP_VALIDATE_STATS_EN is defined.
interface vp_validate_if;
    logic [1:0][31:1] pred_pc_e1_i;
    logic [1:0][31:0] pred_result_e1_i;
    logic [1:0]       pred_conf_e1_i;
    logic [1:0]       pred_valid_e1_i;
    logic [1:0][31:1] wb_pc_i;
    logic [1:0][31:0] wb_result_i;
    logic [1:0]       wb_valid_i;
    logic             flush_i;
    logic [1:0][31:1] fb_pc_o;
    logic [1:0][31:0] fb_actual_o;
    logic [1:0]       fb_mispredict_o;
    logic [1:0]       fb_conf_o;
    logic [1:0]       fb_valid_o;
    logic             full_o;
    logic             empty_o;
    logic             overflow_o;
    logic             pc_err_o;
`ifdef VP_VALIDATE_STATS_EN
    logic [31:0]      stat_pred_o;
    logic [31:0]      stat_mispred_o;
    logic [31:0]      stat_conf_mispred_o;
`endif

    modport master (
        output pred_pc_e1_i, pred_result_e1_i, pred_conf_e1_i, pred_valid_e1_i,
        output wb_pc_i, wb_result_i, wb_valid_i, flush_i,
        input  fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o, fb_valid_o,
        input  full_o, empty_o, overflow_o, pc_err_o
`ifdef VP_VALIDATE_STATS_EN
        , input stat_pred_o, stat_mispred_o, stat_conf_mispred_o
`endif
    );

    modport slave (
        input  pred_pc_e1_i, pred_result_e1_i, pred_conf_e1_i, pred_valid_e1_i,
        input  wb_pc_i, wb_result_i, wb_valid_i, flush_i,
        output fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o, fb_valid_o,
        output full_o, empty_o, overflow_o, pc_err_o
`ifdef VP_VALIDATE_STATS_EN
        , output stat_pred_o, stat_mispred_o, stat_conf_mispred_o
`endif
    );
endinterface

// File: rtl/vp_validate.sv
// vp_validate: in-order queue of E1 value predictions, popped at writeback
// and compared with the actual result; feedback is registered one cycle.
// Optional macro VP_VALIDATE_STATS_EN adds saturating 32-bit counters of
// feedback lanes, mispredicts and confident mispredicts.
module vp_validate #(
    parameter int P_DEPTH    = 16,
    parameter int P_NUM_PRED = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vp_validate_if.slave bus
);
    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:1] pc;
        logic [31:0] result;
        logic        conf;
    } entry_t;

    entry_t           mem_q [P_DEPTH];
    entry_t           mem_d [P_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       fb_valid_q, fb_valid_d;
    logic [1:0]       fb_mispredict_q, fb_mispredict_d;
    logic [1:0]       fb_conf_q, fb_conf_d;
    logic [1:0][31:1] fb_pc_q, fb_pc_d;
    logic [1:0][31:0] fb_actual_q, fb_actual_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             pc_err_q, pc_err_d;

    logic [CW-1:0]    free_slots;
    logic [1:0]       n_req, n_push, n_wb, n_pop;
    entry_t           push_ent [2];
    entry_t           pop_ent;
    logic [1:0][31:1] wb_pc_c;
    logic [1:0][31:0] wb_res_c;

    // Lane compaction and push/pop limiting against the cycle-start count.
    always_comb begin
        push_ent[0].pc     = bus.pred_valid_e1_i[0] ? bus.pred_pc_e1_i[0] : bus.pred_pc_e1_i[1];
        push_ent[0].result = bus.pred_valid_e1_i[0] ? bus.pred_result_e1_i[0] : bus.pred_result_e1_i[1];
        push_ent[0].conf   = bus.pred_valid_e1_i[0] ? bus.pred_conf_e1_i[0] : bus.pred_conf_e1_i[1];
        push_ent[1].pc     = bus.pred_pc_e1_i[1];
        push_ent[1].result = bus.pred_result_e1_i[1];
        push_ent[1].conf   = bus.pred_conf_e1_i[1];

        wb_pc_c[0]  = bus.wb_valid_i[0] ? bus.wb_pc_i[0] : bus.wb_pc_i[1];
        wb_res_c[0] = bus.wb_valid_i[0] ? bus.wb_result_i[0] : bus.wb_result_i[1];
        wb_pc_c[1]  = bus.wb_pc_i[1];
        wb_res_c[1] = bus.wb_result_i[1];

        n_req = {1'b0, bus.pred_valid_e1_i[0]} + {1'b0, bus.pred_valid_e1_i[1]};
        n_wb  = {1'b0, bus.wb_valid_i[0]} + {1'b0, bus.wb_valid_i[1]};

        free_slots = CW'(P_DEPTH) - count_q;

        if (free_slots >= CW'(2)) begin
            n_push = n_req;
        end else if (free_slots == CW'(1)) begin
            n_push = (n_req != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_push = 2'd0;
        end

        if (count_q >= CW'(2)) begin
            n_pop = n_wb;
        end else if (count_q == CW'(1)) begin
            n_pop = (n_wb != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_pop = 2'd0;
        end
    end

    // Next state: storage writes, pointer/count update, feedback compare.
    always_comb begin
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        fb_valid_d      = '0;
        fb_mispredict_d = fb_mispredict_q;
        fb_conf_d       = fb_conf_q;
        fb_pc_d         = fb_pc_q;
        fb_actual_d     = fb_actual_q;
        overflow_d      = 1'b0;
        pc_err_d        = 1'b0;
        pop_ent         = '0;

        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (2'(i) < n_push) begin
                    mem_d[wr_ptr_q + AW'(i)] = push_ent[i];
                end
            end

            // Popped entries land on fb lanes in compacted wb order.
            for (int k = 0; k < P_NUM_PRED; k++) begin
                if (2'(k) < n_pop) begin
                    pop_ent = mem_q[rd_ptr_q + AW'(k)];
                    if (pop_ent.pc == wb_pc_c[k]) begin
                        fb_valid_d[k]      = 1'b1;
                        fb_mispredict_d[k] = (pop_ent.result != wb_res_c[k]);
                        fb_conf_d[k]       = pop_ent.conf;
                        fb_pc_d[k]         = wb_pc_c[k];
                        fb_actual_d[k]     = wb_res_c[k];
                    end else begin
                        pc_err_d = 1'b1;
                    end
                end
            end

            overflow_d = (n_push != n_req);
            wr_ptr_d   = wr_ptr_q + AW'(n_push);
            rd_ptr_d   = rd_ptr_q + AW'(n_pop);
            count_d    = count_q + CW'(n_push) - CW'(n_pop);
        end

        full_d  = (count_d > CW'(P_DEPTH - 2));
        empty_d = (count_d == '0);
    end

    // Queue storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Control and feedback registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fb_valid_q      <= '0;
            fb_mispredict_q <= '0;
            fb_conf_q       <= '0;
            fb_pc_q         <= '0;
            fb_actual_q     <= '0;
            full_q          <= 1'b0;
            empty_q         <= 1'b1;
            overflow_q      <= 1'b0;
            pc_err_q        <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            fb_valid_q      <= fb_valid_d;
            fb_mispredict_q <= fb_mispredict_d;
            fb_conf_q       <= fb_conf_d;
            fb_pc_q         <= fb_pc_d;
            fb_actual_q     <= fb_actual_d;
            full_q          <= full_d;
            empty_q         <= empty_d;
            overflow_q      <= overflow_d;
            pc_err_q        <= pc_err_d;
        end
    end

    assign bus.fb_pc_o         = fb_pc_q;
    assign bus.fb_actual_o     = fb_actual_q;
    assign bus.fb_mispredict_o = fb_mispredict_q;
    assign bus.fb_conf_o       = fb_conf_q;
    assign bus.fb_valid_o      = fb_valid_q;
    assign bus.full_o          = full_q;
    assign bus.empty_o         = empty_q;
    assign bus.overflow_o      = overflow_q;
    assign bus.pc_err_o        = pc_err_q;

`ifdef VP_VALIDATE_STATS_EN
    logic [31:0] stat_pred_q, stat_pred_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;
    logic [31:0] stat_conf_mispred_q, stat_conf_mispred_d;
    logic [1:0]  mis_lanes, conf_mis_lanes;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] lanes);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(lanes[0]) + 33'(lanes[1]);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Counters track the feedback being registered this cycle; flush leaves them alone.
    always_comb begin
        mis_lanes           = fb_valid_d & fb_mispredict_d;
        conf_mis_lanes      = mis_lanes & fb_conf_d;
        stat_pred_d         = sat_add(stat_pred_q, fb_valid_d);
        stat_mispred_d      = sat_add(stat_mispred_q, mis_lanes);
        stat_conf_mispred_d = sat_add(stat_conf_mispred_q, conf_mis_lanes);
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_pred_q         <= '0;
            stat_mispred_q      <= '0;
            stat_conf_mispred_q <= '0;
        end else begin
            stat_pred_q         <= stat_pred_d;
            stat_mispred_q      <= stat_mispred_d;
            stat_conf_mispred_q <= stat_conf_mispred_d;
        end
    end

    assign bus.stat_pred_o         = stat_pred_q;
    assign bus.stat_mispred_o      = stat_mispred_q;
    assign bus.stat_conf_mispred_o = stat_conf_mispred_q;
`endif
endmodule

// File: tb/tb_vp_validate.sv
// tb_vp_validate: directed test-plan sequences followed by randomized
// traffic; a queue-based reference model produces per-cycle expectations
// that a separate monitor process compares against the DUT.
module tb_vp_validate;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vp_validate_if bus();

    vp_validate #(.P_DEPTH(DEPTH), .P_NUM_PRED(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:1] pc;
        logic [31:0] res;
        logic        conf;
    } ment_t;

    typedef struct packed {
        logic [1:0]       fv;
        logic [1:0]       mis;
        logic [1:0]       conf;
        logic [1:0][31:1] pc;
        logic [1:0][31:0] act;
        logic             ovf;
        logic             err;
        logic             full;
        logic             empty;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    exp_t  mx;
    int    checks = 0;
    int    failures = 0;
    int unsigned m_pred = 0, m_mis = 0, m_cmis = 0;

    logic [1:0]       s_pv, s_pconf, s_wv;
    logic [1:0][31:1] s_ppc, s_wpc;
    logic [1:0][31:0] s_pres, s_wres;
    logic             s_flush, s_rst;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic clr();
        s_pv = '0; s_pconf = '0; s_wv = '0; s_ppc = '0; s_wpc = '0;
        s_pres = '0; s_wres = '0; s_flush = 1'b0; s_rst = 1'b0;
    endtask

    // Drive one cycle of stimulus and record what the queue model predicts.
    task automatic step();
        exp_t  x;
        ment_t e;
        int    start, acc, k;
        @(negedge clk);
        rst                  = s_rst;
        bus.pred_pc_e1_i     = s_ppc;
        bus.pred_result_e1_i = s_pres;
        bus.pred_conf_e1_i   = s_pconf;
        bus.pred_valid_e1_i  = s_pv;
        bus.wb_pc_i          = s_wpc;
        bus.wb_result_i      = s_wres;
        bus.wb_valid_i       = s_wv;
        bus.flush_i          = s_flush;
        x = '0;
        if (s_rst) begin
            mq.delete();
            m_pred = 0; m_mis = 0; m_cmis = 0;
        end else if (s_flush) begin
            mq.delete();
        end else begin
            start = mq.size();
            k = 0;
            for (int l = 0; l < 2; l++) begin
                if (s_wv[l]) begin
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        if (e.pc == s_wpc[l]) begin
                            x.fv[k]   = 1'b1;
                            x.mis[k]  = (e.res != s_wres[l]);
                            x.conf[k] = e.conf;
                            x.pc[k]   = s_wpc[l];
                            x.act[k]  = s_wres[l];
                            m_pred++;
                            if (x.mis[k]) m_mis++;
                            if (x.mis[k] && e.conf) m_cmis++;
                        end else begin
                            x.err = 1'b1;
                        end
                    end
                    k++;
                end
            end
            acc = 0;
            for (int l = 0; l < 2; l++) begin
                if (s_pv[l]) begin
                    if (acc < DEPTH - start) begin
                        e.pc = s_ppc[l]; e.res = s_pres[l]; e.conf = s_pconf[l];
                        mq.push_back(e);
                        acc++;
                    end else begin
                        x.ovf = 1'b1;
                    end
                end
            end
        end
        x.full  = (mq.size() > DEPTH - 2);
        x.empty = (mq.size() == 0);
        exp_q.push_back(x);
    endtask

    // Writeback on the given lanes using the model's upcoming entries, correct results.
    task automatic wb_auto(input logic [1:0] v);
        int idx;
        idx = 0;
        s_wv = v;
        for (int l = 0; l < 2; l++) begin
            if (v[l]) begin
                if (idx < mq.size()) begin
                    s_wpc[l]  = mq[idx].pc;
                    s_wres[l] = mq[idx].res;
                end
                idx++;
            end
        end
    endtask

    task automatic rand_stim(input int push_pct, input int wb_pct);
        clr();
        for (int l = 0; l < 2; l++) begin
            if ($urandom_range(99) < push_pct) begin
                s_pv[l]    = 1'b1;
                s_ppc[l]   = 31'($urandom);
                s_pres[l]  = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
                s_pconf[l] = 1'($urandom_range(1));
            end
            s_wv[l] = ($urandom_range(99) < wb_pct);
        end
        wb_auto(s_wv);
        for (int l = 0; l < 2; l++) begin
            if (s_wv[l]) begin
                if ($urandom_range(1) == 0) s_wres[l] = $urandom;
                if (s_wv == 2'b0) s_wpc[l] = 31'($urandom);
            end
        end
        // PC errors only on single-lane writebacks.
        if ((s_wv == 2'b01 || s_wv == 2'b10) && $urandom_range(15) == 0) begin
            s_wpc = s_wpc ^ {31'h4, 31'h4};
        end
        s_flush = ($urandom_range(127) == 0);
    endtask

    // Monitor: one expectation per registered cycle, sampled after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            chk("fb_valid", 64'(bus.fb_valid_o), 64'(mx.fv));
            for (int l = 0; l < 2; l++) begin
                if (mx.fv[l]) begin
                    chk("fb_mispredict", 64'(bus.fb_mispredict_o[l]), 64'(mx.mis[l]));
                    chk("fb_conf", 64'(bus.fb_conf_o[l]), 64'(mx.conf[l]));
                    chk("fb_pc", 64'(bus.fb_pc_o[l]), 64'(mx.pc[l]));
                    chk("fb_actual", 64'(bus.fb_actual_o[l]), 64'(mx.act[l]));
                end
            end
            chk("overflow", 64'(bus.overflow_o), 64'(mx.ovf));
            chk("pc_err", 64'(bus.pc_err_o), 64'(mx.err));
            chk("full", 64'(bus.full_o), 64'(mx.full));
            chk("empty", 64'(bus.empty_o), 64'(mx.empty));
        end
    end

    initial begin
        clr();
        s_rst = 1'b1;
        step(); step();
        clr();
        repeat (10) step();

        // Single prediction, correct, confident.
        s_pv = 2'b01; s_ppc[0] = 31'h100; s_pres[0] = 32'h5; s_pconf[0] = 1'b1;
        step();
        clr(); step(); step();
        s_wv = 2'b01; s_wpc[0] = 31'h100; s_wres[0] = 32'h5;
        step();
        clr(); step(); step();

        // Two lanes, second mispredicts.
        s_pv = 2'b11; s_ppc = {31'h204, 31'h200}; s_pres = {32'hB, 32'hA}; s_pconf = 2'b10;
        step();
        clr();
        s_wv = 2'b11; s_wpc = {31'h204, 31'h200}; s_wres = {32'hC, 32'hA};
        step();
        clr(); step();

        // Fill to 15, then a two-lane push overflows by one.
        for (int i = 0; i < 8; i++) begin
            clr();
            s_pv = (i == 7) ? 2'b01 : 2'b11;
            s_ppc  = {31'(32'h404 + i * 8), 31'(32'h400 + i * 8)};
            s_pres = {32'(i * 2 + 1), 32'(i * 2)};
            s_pconf = 2'(i);
            step();
        end
        clr();
        s_pv = 2'b11; s_ppc = {31'h4FC, 31'h4F8}; s_pres = {32'h77, 32'h66};
        step();
        clr(); step();
        for (int i = 0; i < 8; i++) begin
            clr(); wb_auto(2'b11); step();
        end
        clr(); step();
        s_pv = 2'b11; s_ppc = {31'h504, 31'h500}; s_pres = {32'h2, 32'h1}; s_pconf = 2'b01;
        step();
        clr(); wb_auto(2'b11); s_wres[1] = 32'h3; step();
        clr(); step();

        // PC mismatch consumes the entry.
        s_pv = 2'b01; s_ppc[0] = 31'h300; s_pres[0] = 32'h9;
        step();
        clr(); s_wv = 2'b01; s_wpc[0] = 31'h304; s_wres[0] = 32'h9;
        step();
        clr(); step();

        // Flush with concurrent push and writeback.
        for (int i = 0; i < 2; i++) begin
            clr(); s_pv = 2'b11;
            s_ppc = {31'(32'h604 + i * 8), 31'(32'h600 + i * 8)};
            s_pres = {32'h11, 32'h10};
            step();
        end
        clr(); s_flush = 1'b1; s_pv = 2'b01; s_ppc[0] = 31'h700; wb_auto(2'b01);
        step();
        clr(); s_pv = 2'b10; s_ppc[1] = 31'h710; s_pres[1] = 32'h44; s_pconf[1] = 1'b1;
        step();
        clr(); s_wv = 2'b10; s_wpc[1] = 31'h710; s_wres[1] = 32'h45;
        step();
        clr(); step();

        // Randomized phases with different fill pressure.
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 300; c++) begin
                case (ph % 3)
                    0:       rand_stim(70, 30);
                    1:       rand_stim(30, 70);
                    default: rand_stim(50, 50);
                endcase
                step();
            end
        end

        clr();
        repeat (3) step();
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
`ifdef VP_VALIDATE_STATS_EN
        chk("stat_pred", 64'(bus.stat_pred_o), 64'(m_pred));
        chk("stat_mispred", 64'(bus.stat_mispred_o), 64'(m_mis));
        chk("stat_conf_mispred", 64'(bus.stat_conf_mispred_o), 64'(m_cmis));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
